// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: access sizes, bubble instruction,
// MEM-stage FSM encoding and lane offset helper.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mau_state_e;

  // Effective byte lane; half/word ignore the low bits.
  function automatic logic [1:0] lane_off(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [1:0] off;
    off = 2'b00;
    unique case (size)
      SZ_BYTE: off = lo;
      SZ_HALF: off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage (combinational).
// Ports: st_* -> be/wdata for stores; ld_* -> extracted, extended load.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  st_off;
  logic [1:0]  ld_off;
  logic [31:0] ld_sh;

  assign st_off = lane_off(st_size, st_lo);
  assign ld_off = lane_off(ld_size, ld_lo);
  assign ld_sh  = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    unique case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_sh;
    unique case (ld_size)
      SZ_BYTE:
        ld_data = {{24{~ld_unsigned & ld_sh[7]}}, ld_sh[7:0]};
      SZ_HALF:
        ld_data = {{16{~ld_unsigned & ld_sh[15]}}, ld_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data bus, stall, MEM_* bundle.
// Ports: ex_* from EX/MEM, mem_* to MEM/WB, dm_* data bus.
// Option: MEM_ALIGN_CHK_EN rejects misaligned half/word with a bus error.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP      = NOP_INST,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic        ex_regdst,
  input  logic        ex_link,
  input  logic [4:0]  ex_wraddr,
  input  logic [31:0] ex_pc_4,
  input  logic [31:0] ex_inst,
  output logic        mem_memtoreg,
  output logic        mem_regwrite,
  output logic        mem_regdst,
  output logic        mem_link,
  output logic [31:0] mem_data,
  output logic [4:0]  mem_wraddr,
  output logic [31:0] mem_pc_4,
  output logic [31:0] mem_inst,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int WDW = $clog2(MAX_WAIT + 1);

  mau_state_e  state_q, state_d;
  logic [WDW-1:0] wd_cnt;
  logic        mem_op, misal, start, expire, bubble;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data, lbuf;
  logic [1:0]  ld_size_q, ld_lo_q;
  logic        ld_uns_q, is_load_q, err_q;

  assign mem_op = ex_memread | ex_memwrite;

`ifdef MEM_ALIGN_CHK_EN
  assign misal = mem_op &&
    ((ex_size == SZ_HALF && ex_alu_result[0]) ||
     (ex_size[1] && ex_alu_result[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign start  = (state_q == S_IDLE) && mem_op && !misal;
  assign expire = (state_q == S_WAIT) && !dm_ack &&
                  (wd_cnt == WDW'(MAX_WAIT - 1));

  mem_lane_align u_align (
    .st_size    (ex_size),
    .st_lo      (ex_alu_result[1:0]),
    .st_data    (ex_store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_size    (ld_size_q),
    .ld_lo      (ld_lo_q),
    .ld_unsigned(ld_uns_q),
    .ld_rdata   (dm_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (dm_ack || expire) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_addr   <= '0;
      dm_we     <= 1'b0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      ld_size_q <= '0;
      ld_lo_q   <= '0;
      ld_uns_q  <= 1'b0;
      is_load_q <= 1'b0;
      wd_cnt    <= '0;
      lbuf      <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (start) begin
        dm_addr   <= {ex_alu_result[31:2], 2'b00};
        dm_we     <= ex_memwrite;
        dm_be     <= st_be;
        dm_wdata  <= st_wdata;
        ld_size_q <= ex_size;
        ld_lo_q   <= ex_alu_result[1:0];
        ld_uns_q  <= ex_unsigned;
        is_load_q <= ~ex_memwrite;
        wd_cnt    <= '0;
      end
      if (state_q == S_WAIT) begin
        wd_cnt <= wd_cnt + WDW'(1);
        // Ack has priority over a same-cycle expiry.
        if (dm_ack) begin
          lbuf <= ld_data;
        end else if (expire) begin
          lbuf  <= '0;
          err_q <= 1'b1;
        end
      end
      if (state_q == S_IDLE && misal) err_q <= 1'b1;
    end
  end

  assign mem_bus_err = err_q;

  always_comb begin
    dm_req       = (state_q == S_WAIT);
    mem_stall    = 1'b0;
    bubble       = 1'b0;
    mem_memtoreg = ex_memtoreg;
    mem_regwrite = ex_regwrite;
    mem_regdst   = ex_regdst;
    mem_link     = ex_link;
    mem_data     = ex_alu_result;
    mem_wraddr   = ex_wraddr;
    mem_pc_4     = ex_pc_4;
    mem_inst     = ex_inst;
    unique case (state_q)
      S_IDLE: begin
        mem_stall = start;
        bubble    = mem_op;
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        bubble    = 1'b1;
      end
      S_DONE:  if (is_load_q) mem_data = lbuf;
      default: ;
    endcase
    if (bubble) begin
      mem_memtoreg = 1'b0;
      mem_regwrite = 1'b0;
      mem_regdst   = 1'b0;
      mem_link     = 1'b0;
      mem_data     = '0;
      mem_wraddr   = '0;
      mem_inst     = NOP;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random loads/stores/ALU ops,
// memory responder with random latency, retire and bus monitors.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 16;
  localparam logic [31:0] NOPW = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc_4, ex_inst;
  logic        ex_memread, ex_memwrite, ex_unsigned;
  logic        ex_memtoreg, ex_regwrite, ex_regdst, ex_link;
  logic [1:0]  ex_size;
  logic [4:0]  ex_wraddr;
  logic        mem_memtoreg, mem_regwrite, mem_regdst, mem_link;
  logic [31:0] mem_data, mem_pc_4, mem_inst;
  logic [4:0]  mem_wraddr;
  logic        mem_stall, mem_bus_err;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_regdst(ex_regdst), .ex_link(ex_link),
    .ex_wraddr(ex_wraddr), .ex_pc_4(ex_pc_4), .ex_inst(ex_inst),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .mem_regdst(mem_regdst), .mem_link(mem_link),
    .mem_data(mem_data), .mem_wraddr(mem_wraddr),
    .mem_pc_4(mem_pc_4), .mem_inst(mem_inst),
    .mem_stall(mem_stall), .mem_bus_err(mem_bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ctl;
    logic [4:0]  wraddr;
    logic [31:0] pc4;
    logic [31:0] inst;
    int          stall;
    logic        err;
    logic        misal;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int resp_delay = 1;
  logic [31:0] resp_rdata = '0;
  logic active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: ack after resp_delay WAIT cycles (0 = never).
  // Stray acks while no request is pending must be ignored.
  initial begin
    int wc;
    wc = 0;
    dm_ack = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wc = 0;
        dm_ack = 1'b0;
      end else if (dm_req) begin
        wc++;
        if (resp_delay != 0 && wc == resp_delay) begin
          dm_ack = 1'b1;
          dm_rdata = resp_rdata;
        end else begin
          dm_ack = 1'b0;
          dm_rdata = $urandom;
        end
      end else begin
        wc = 0;
        dm_ack = ($urandom_range(0, 3) == 0);
        dm_rdata = $urandom;
      end
    end
  end

  // Monitor: bus fields while requesting, bubbles while stalled,
  // full bundle on retirement, error pulse every cycle.
  initial begin
    int stall_cnt;
    logic prev_misal, prev_req, exp_err;
    exp_t e;
    bus_t cb;
    stall_cnt = 0;
    prev_misal = 1'b0;
    prev_req = 1'b0;
    cb = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
        prev_misal = 1'b0;
        prev_req = 1'b0;
        continue;
      end
      if (dm_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
          else cb = bus_q.pop_front();
        end
        chk("dm_addr", dm_addr, cb.addr);
        chk("dm_we", {31'd0, dm_we}, {31'd0, cb.we});
        chk("dm_be", {28'd0, dm_be}, {28'd0, cb.be});
        if (cb.we) chk("dm_wdata", dm_wdata, cb.wdata);
      end
      prev_req = dm_req;
      exp_err = prev_misal;
      prev_misal = 1'b0;
      if (active && mem_stall) begin
        stall_cnt++;
        chk("stall_inst", mem_inst, NOPW);
        chk("stall_rw", {31'd0, mem_regwrite}, 32'd0);
      end else if (active) begin
        if (exp_q.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mem_data", mem_data, e.data);
          chk("mem_ctl", {28'd0, mem_memtoreg, mem_regwrite,
                          mem_regdst, mem_link}, {28'd0, e.ctl});
          chk("mem_wraddr", {27'd0, mem_wraddr}, {27'd0, e.wraddr});
          chk("mem_pc_4", mem_pc_4, e.pc4);
          chk("mem_inst", mem_inst, e.inst);
          chk("stall_cycles", stall_cnt, e.stall);
          exp_err = exp_err | e.err;
          prev_misal = e.misal;
        end
        stall_cnt = 0;
      end
      chk("bus_err", {31'd0, mem_bus_err}, {31'd0, exp_err});
    end
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Issue one EX/MEM bundle, predict its result, hold until retired.
  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdat, input int dly);
    exp_t e;
    bus_t b;
    int nb, off, waits;
    logic mop, mis, done;
    logic [31:0] mask, v;
    @(posedge clk);
    #1;
    ex_memread = rd;
    ex_memwrite = wr;
    ex_size = sz;
    ex_unsigned = uns;
    ex_alu_result = a;
    ex_store_data = d;
    ex_memtoreg = 1'($urandom);
    ex_regwrite = 1'($urandom);
    ex_regdst = 1'($urandom);
    ex_link = 1'($urandom);
    ex_wraddr = 5'($urandom);
    ex_pc_4 = $urandom;
    ex_inst = $urandom;
    resp_delay = dly;
    resp_rdata = rdat;
    mop = rd | wr;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = (int'(a[1:0]) / nb) * nb;
`ifdef MEM_ALIGN_CHK_EN
    mis = mop && (int'(a[1:0]) % nb != 0);
`else
    mis = 1'b0;
`endif
    e.ctl = {ex_memtoreg, ex_regwrite, ex_regdst, ex_link};
    e.wraddr = ex_wraddr;
    e.pc4 = ex_pc_4;
    e.inst = ex_inst;
    e.data = a;
    e.stall = 0;
    e.err = 1'b0;
    e.misal = mis;
    if (mis) begin
      e.ctl = '0;
      e.wraddr = '0;
      e.inst = NOPW;
      e.data = '0;
    end else if (mop) begin
      waits = (dly == 0) ? MAX_WAIT : dly;
      e.stall = 1 + waits;
      e.err = (dly == 0);
      if (!wr) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rdat >> (8 * off)) & mask;
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        e.data = (dly == 0) ? 32'd0 : v;
      end
      b.addr = a & 32'hFFFF_FFFC;
      b.we = wr;
      for (int k = 0; k < 4; k++) begin
        b.be[k] = (k >= off) && (k < off + nb);
        b.wdata[8 * k +: 8] = d[8 * (k % nb) +: 8];
      end
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
    active = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL retire_timeout: stall still %b after 40 cycles",
               mem_stall);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "retire timeout");
    end
  endtask

  task automatic idle_inputs();
    ex_memread = 1'b0;
    ex_memwrite = 1'b0;
    ex_size = 2'd0;
    ex_unsigned = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_memtoreg = 1'b0;
    ex_regwrite = 1'b0;
    ex_regdst = 1'b0;
    ex_link = 1'b0;
    ex_wraddr = '0;
    ex_pc_4 = '0;
    ex_inst = '0;
  endtask

  initial begin
    int op, r, dly;
    bus_t b;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_we", {31'd0, dm_we}, 32'd0);
    chk("rst_err", {31'd0, mem_bus_err}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_be", {28'd0, dm_be}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    #2 rst_n = 1'b1;

    issue(0, 0, 2'd2, 0, 32'h0000_1234, 32'h5, 32'h0, 1);
    issue(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 32'h8012_3456, 1);
    issue(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h8012_3456, 1);
    issue(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 2);
    issue(1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 32'h1111_2222, 0);
    issue(1, 0, 2'd2, 0, 32'h0000_0304, 32'h0, 32'h3333_4444, MAX_WAIT);
    issue(1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 32'hCAFE_BABE, 1);
    issue(1, 0, 2'd1, 0, 32'h0000_0203, 32'h0, 32'h8765_4321, 3);
    issue(1, 1, 2'd3, 0, 32'h0000_0408, 32'h0BAD_F00D, 32'h0, 1);

    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 1) ? MAX_WAIT : $urandom_range(1, 5);
      issue(op[0], op[1], 2'($urandom), 1'($urandom), $urandom,
            $urandom, $urandom, dly);
    end

    // Reset in the middle of a pending access.
    @(posedge clk);
    #1;
    active = 1'b0;
    idle_inputs();
    ex_memread = 1'b1;
    ex_size = 2'd2;
    ex_alu_result = 32'h0000_0400;
    resp_delay = 0;
    b.addr = 32'h0000_0400;
    b.we = 1'b0;
    b.be = 4'b1111;
    b.wdata = '0;
    bus_q.push_back(b);
    repeat (5) @(negedge clk);
    chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, dm_req}, 32'd0);
    chk("async_rst_addr", dm_addr, 32'd0);
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("post_rst_req", {31'd0, dm_req}, 32'd0);
    issue(1, 0, 2'd0, 1, 32'h0000_0501, 32'h0, 32'h0000_AB00, 2);
    @(posedge clk);
    #1;
    active = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    finish_run();
  end

  initial begin
    #500000;
    n_chk++;
    $display("FAIL global_timeout: run did not finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "global timeout");
  end

endmodule
